// File: rtl/a000010_naive_par_lanes_if.sv
// a000010_naive_par_lanes_if: start/operand/result bus of the parallel totient counter.
// Carries the abort line only when A000010_PAR_ABORT_EN is defined.
interface a000010_naive_par_lanes_if #(
    parameter int W = 18
);
    logic         start;
    logic [W-1:0] n;
    logic [W-1:0] start_offset;
    logic [W-1:0] increment;
    logic [W-1:0] result;
    logic         result_ready;
    logic         busy;
`ifdef A000010_PAR_ABORT_EN
    logic         abort;
    modport master (output start, n, start_offset, increment, abort, input result, result_ready, busy);
    modport slave (input start, n, start_offset, increment, abort, output result, result_ready, busy);
`else
    modport master (output start, n, start_offset, increment, input result, result_ready, busy);
    modport slave (input start, n, start_offset, increment, output result, result_ready, busy);
`endif
endinterface

// File: rtl/a000010_naive_par_lanes.sv
// a000010_naive_par_lanes: counts candidates coprime to n using LANES one-op-per-cycle binary-gcd lanes.
// Defining A000010_PAR_ABORT_EN adds an abort input that drops back to IDLE keeping the old result.
module a000010_naive_par_lanes #(
    parameter int W     = 18,
    parameter int LANES = 4
) (
    input logic clk,
    input logic reset,
    a000010_naive_par_lanes_if.slave bus
);
    localparam int CW = W + $clog2(LANES) + 1;
    typedef enum logic [1:0] {IDLE, INIT, RUN, SUM} state_t;
    state_t state, state_nx;
    logic [W-1:0] n_q, off_q, inc_q, sum, result_q;
    logic [CW-1:0] stride;
    logic [CW-1:0] cand [LANES];
    logic [CW-1:0] init_c [LANES];
    logic [CW-1:0] next_c [LANES];
    logic [W-1:0] a [LANES];
    logic [W-1:0] b [LANES];
    logic [W-1:0] na [LANES];
    logic [W-1:0] nb [LANES];
    logic [W-1:0] cnt [LANES];
    logic [LANES-1:0] done, init_done, fin, cop;
    logic abort;
`ifdef A000010_PAR_ABORT_EN
    assign abort = bus.abort;
`else
    assign abort = 1'b0;
`endif
    // Candidate past n, past the W-bit range, or an all-ones offset ends a lane.
    function automatic logic stop(input logic [CW-1:0] c, input logic [W-1:0] lim, input logic [W-1:0] off);
        return c > CW'(lim) || c[CW-1:W] != '0 || &off;
    endfunction
    always_comb begin
        stride = CW'(inc_q) * CW'(LANES);
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            init_c[k] = CW'(off_q) + CW'(1) + CW'(k) * CW'(inc_q);
            init_done[k] = stop(init_c[k], n_q, off_q) || (inc_q == '0 && k != 0);
            next_c[k] = cand[k] + stride;
            fin[k] = a[k] == '0 || b[k] == '0 || a[k] == b[k] || !(a[k][0] || b[k][0]);
            cop[k] = (a[k] | b[k]) == W'(1);
            na[k] = !a[k][0] ? a[k] >> 1 : (b[k][0] && a[k] > b[k]) ? a[k] - b[k] : a[k];
            nb[k] = (a[k][0] && !b[k][0]) ? b[k] >> 1 : (a[k][0] && b[k][0] && b[k] > a[k]) ? b[k] - a[k] : b[k];
            sum = sum + cnt[k];
        end
    end
    always_comb begin
        state_nx = state;
        if (bus.start) state_nx = INIT;
        else if (abort && state != IDLE) state_nx = IDLE;
        else if (state == INIT) state_nx = &init_done ? SUM : RUN;
        else if (state == RUN) state_nx = &done ? SUM : RUN;
        else if (state == SUM) state_nx = IDLE;
    end
    assign bus.busy = state != IDLE;
    assign bus.result_ready = state == IDLE && !bus.start;
    assign bus.result = result_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            n_q <= '0;
            off_q <= '0;
            inc_q <= '0;
            result_q <= '0;
            done <= '0;
            for (int k = 0; k < LANES; k++) begin
                cand[k] <= '0;
                a[k] <= '0;
                b[k] <= '0;
                cnt[k] <= '0;
            end
        end else begin
            state <= state_nx;
            if (bus.start) begin
                n_q <= bus.n;
                off_q <= bus.start_offset;
                inc_q <= bus.increment;
            end
            if (state == SUM && state_nx == IDLE) result_q <= sum;
            for (int k = 0; k < LANES; k++) begin
                if (state == INIT) begin
                    cand[k] <= init_c[k];
                    done[k] <= init_done[k];
                    a[k] <= n_q;
                    b[k] <= init_c[k][W-1:0];
                    cnt[k] <= '0;
                end else if (state == RUN && !done[k]) begin
                    if (fin[k]) begin
                        // A zero increment would revisit the same candidate forever.
                        cnt[k] <= cnt[k] + W'(cop[k]);
                        cand[k] <= next_c[k];
                        done[k] <= inc_q == '0 || stop(next_c[k], n_q, off_q);
                        a[k] <= n_q;
                        b[k] <= next_c[k][W-1:0];
                    end else begin
                        a[k] <= na[k];
                        b[k] <= nb[k];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_a000010_naive_par_lanes.sv
// tb_a000010_naive_par_lanes: drives W18/L4, W18/L1 and W8/L4 counters in lockstep with directed vectors.
module tb_a000010_naive_par_lanes;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [17:0] n = '0, off = '0, inc = '0;
    int passed = 0, total = 0;
    int cyc;
    logic bz;
    always #5 clk = ~clk;

    a000010_naive_par_lanes_if #(.W(18)) b4 ();
    a000010_naive_par_lanes_if #(.W(18)) b1 ();
    a000010_naive_par_lanes_if #(.W(8)) b8 ();
    assign b4.start = start;
    assign b4.n = n;
    assign b4.start_offset = off;
    assign b4.increment = inc;
    assign b1.start = start;
    assign b1.n = n;
    assign b1.start_offset = off;
    assign b1.increment = inc;
    assign b8.start = start;
    assign b8.n = n[7:0];
    assign b8.start_offset = off[7:0];
    assign b8.increment = inc[7:0];
`ifdef A000010_PAR_ABORT_EN
    logic abort = 1'b0;
    assign b4.abort = abort;
    assign b1.abort = abort;
    assign b8.abort = abort;
`endif

    a000010_naive_par_lanes #(.W(18), .LANES(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
    a000010_naive_par_lanes #(.W(18), .LANES(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    a000010_naive_par_lanes #(.W(8), .LANES(4)) u8 (.clk(clk), .reset(reset), .bus(b8));

    typedef struct {
        logic [17:0] n;
        logic [17:0] off;
        logic [17:0] inc;
        int          exp;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Call at a negedge; returns negedges from start until all three are ready again.
    task automatic run(input logic [17:0] nn, input logic [17:0] oo, input logic [17:0] ii,
                       output int c, output logic busy_seen);
        n = nn;
        off = oo;
        inc = ii;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_seen = b4.busy & b1.busy & b8.busy;
        c = 1;
        while (!(b4.result_ready && b1.result_ready && b8.result_ready) && c < 10000) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic check_all(input string name, input int exp);
        check({name, " L4"}, int'(b4.result), exp);
        check({name, " L1"}, int'(b1.result), exp);
        check({name, " W8"}, int'(b8.result), exp);
    endtask

    initial begin
        vecs = '{
            '{18'd10, 18'd0, 18'd1, 4},
            '{18'd15, 18'd0, 18'd2, 4},
            '{18'd12, 18'd0, 18'd1, 4},
            '{18'd255, 18'd250, 18'd3, 2},
            '{18'd10, 18'd2, 18'd0, 1},
            '{18'd10, 18'd3, 18'd0, 0},
            '{18'd0, 18'd0, 18'd1, 0},
            '{18'd1, 18'd0, 18'd1, 1},
            '{18'd10, 18'h3FFFF, 18'd1, 0},
            '{18'd7, 18'd0, 18'd1, 6},
            '{18'd100, 18'd0, 18'd1, 40},
            '{18'd30, 18'd0, 18'd7, 2},
            '{18'd9, 18'd0, 18'd0, 1}
        };
        repeat (2) @(negedge clk);
        check("reset result", int'(b4.result) + int'(b1.result) + int'(b8.result), 0);
        check("reset busy", int'(b4.busy | b1.busy | b8.busy), 0);
        check("reset ready", int'(b4.result_ready & b1.result_ready & b8.result_ready), 1);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            run(vecs[i].n, vecs[i].off, vecs[i].inc, cyc, bz);
            check($sformatf("v%0d busy", i), int'(bz), 1);
            check($sformatf("v%0d terminates", i), int'(cyc < 10000), 1);
            check_all($sformatf("v%0d result", i), vecs[i].exp);
        end

        run(18'd10, 18'h3FFFF, 18'd5, cyc, bz);
        check("max offset latency", int'(cyc <= 3), 1);
        check_all("max offset result", 0);

        n = 18'd100;
        off = 18'd0;
        inc = 18'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun busy", int'(b4.busy & b1.busy & b8.busy), 1);
        run(18'd10, 18'd0, 18'd1, cyc, bz);
        check("restart terminates", int'(cyc < 10000), 1);
        check_all("restart result", 4);

        n = 18'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset result", int'(b4.result) + int'(b1.result) + int'(b8.result), 0);
        check("async reset busy", int'(b4.busy | b1.busy | b8.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post reset ready", int'(b4.result_ready & b1.result_ready & b8.result_ready), 1);

`ifdef A000010_PAR_ABORT_EN
        run(18'd10, 18'd0, 18'd1, cyc, bz);
        check_all("pre abort result", 4);
        n = 18'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", int'(b4.busy | b1.busy | b8.busy), 0);
        check_all("abort held result", 4);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
